minmax_scan_ctrl: RTL
=====================

Name: minmax_scan_ctrl

Overview:
Sequencing controller that streams a configured number of PORT-wide beats through one combinational MINMAX unit and reduces them to a single global minimum or maximum with its global index. It serves the point-cloud engines that need an arg-reduction over long vectors: nearest-neighbour search uses the minimum, farthest-point sampling uses the maximum. It sits between a buffer read port (valid/ready source) and a consumer (valid/ready sink). Each scan is configured by a start pulse.

Parameters:
DATA_WIDTH, 16, width of one element; compared as unsigned
PORT, 4, elements per input beat; power of two, at least 2
MINMAX, 0, 0 = minimum search, 1 = maximum search; passed to the MINMAX sub-module
CNT_WIDTH, 12, width of the beat counter; up to 2^CNT_WIDTH-1 beats per scan
IDX_WIDTH, CNT_WIDTH+$clog2(PORT), width of the global element index (derived)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
CFG_START  in  1  one-cycle pulse that starts a scan; sampled only when CFG_RDY=1
CFG_NUM  in  CNT_WIDTH  number of beats in the scan; sampled with CFG_START
CFG_RDY  out  1  high in IDLE
IN_VLD  in  1  input beat valid
IN_RDY  out  1  controller accepts a beat
IN_DAT  in  DATA_WIDTH*PORT  one beat; element j is IN_DAT[DATA_WIDTH*j +: DATA_WIDTH]
OUT_VLD  out  1  result valid
OUT_RDY  in  1  consumer accepts the result
OUT_VALUE  out  DATA_WIDTH  global min/max value
OUT_IDX  out  IDX_WIDTH  global index = beat_number*PORT + element_index
BUSY  out  1  high in SCAN or DONE

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active low.
- Reset values: state=IDLE, CFG_RDY=1, IN_RDY=0, OUT_VLD=0, OUT_VALUE=0, OUT_IDX=0, BUSY=0, beat counter=0, stored CFG_NUM=0.
- FSM states: IDLE, SCAN, DONE.
- IDLE: CFG_START=1 with CFG_NUM!=0 latches CFG_NUM, clears the counter, and moves to SCAN on the next edge.
  - CFG_START with CFG_NUM=0 is dropped; the state stays IDLE.
  - CFG_START in SCAN or DONE is ignored.
- SCAN: IN_RDY=1, combinationally equal to (state==SCAN). A beat is accepted when IN_VLD and IN_RDY are both high.
- Per accepted beat, MINMAX gives (local_val, local_idx) over the PORT elements. Within a beat, the lowest element index wins a tie.
- Running best:
  - The first beat (counter==0) loads unconditionally: best_val=local_val, best_idx={counter, local_idx}.
  - Later beats replace best only on a strict compare: local_val<best_val for MINMAX=0, local_val>best_val for MINMAX=1. The earliest beat therefore wins ties.
- Counter increments on each accepted beat. The beat accepted with counter==CFG_NUM-1 is the last; the next state is DONE.
- Latency: the last beat is accepted at edge t. OUT_VLD=1 from edge t, so it is visible in the cycle after acceptance. OUT_VALUE and OUT_IDX already include the last beat.
- Gaps in IN_VLD stall the scan without limit. No state change happens without a handshake.
- DONE: OUT_VLD=1; OUT_VALUE and OUT_IDX stay stable until OUT_RDY=1. On the handshake the state returns to IDLE on the same edge, and OUT_VLD falls.
  - OUT_VALUE and OUT_IDX keep their last values in IDLE.
  - A new CFG_START is accepted from the cycle after the handshake.
- CFG_NUM=2^CNT_WIDTH-1: the counter reaches its maximum without wrapping. OUT_IDX is sized so it never overflows.
- rst_n asserted mid-scan aborts immediately. Partial results are discarded and all outputs take their reset values.
- The controller never drives IN_RDY and OUT_VLD high in the same cycle.

Decomposition:
- Shared package:
  - state encoding constants: IDLE=2'd0, SCAN=2'd1, DONE=2'd2
  - the MINMAX-select constants MODE_MIN=0 and MODE_MAX=1, reused by the KNN and FPS controllers
- One sub-module instance: MINMAX (DATA_WIDTH, PORT, MINMAX passed through), fed directly from IN_DAT.
- The running-compare comparator is inline; no further split.

Test Plan:
- MINMAX=0, PORT=4, CFG_NUM=3.
  - Beats {9,7,5,8}, {6,2,4,3}, {1,1,9,9} (element 0 first), IN_VLD held high.
  - Required: OUT_VLD one cycle after the third beat; OUT_VALUE=1, OUT_IDX=8 (beat 2, element 0 wins the tie).
- Tie across beats, CFG_NUM=2.
  - Beats {5,5,5,5}, {5,5,5,5}.
  - Required: OUT_VALUE=5, OUT_IDX=0.
- MINMAX=1 build, CFG_NUM=2.
  - Beats {1,2,3,4}, {0,65535,7,7}.
  - Required: OUT_VALUE=65535, OUT_IDX=5 (unsigned compare).
- Backpressure.
  - IN_VLD toggled randomly on input; OUT_RDY held low 10 cycles.
  - Required: result unchanged and OUT_VLD held throughout; IDLE one edge after OUT_RDY=1; CFG_START during DONE ignored.
- CFG_NUM=0 start: required CFG_RDY stays 1, IN_RDY stays 0, no OUT_VLD.
- Reset mid-operation: rst_n pulsed low after 1 of 3 beats; required all outputs at reset values asynchronously and state IDLE.

Source files
------------

// File: rtl/minmax_scan_ctrl_pkg.sv
// Shared encodings for the arg-reduction scan controllers (KNN/FPS).
package minmax_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MODE_MIN = 0;
  localparam int MODE_MAX = 1;

endpackage

// File: rtl/minmax_scan_ctrl_minmax.sv
// Combinational min/max over the PORT elements of one beat; lowest index wins ties.
module minmax_scan_ctrl_minmax
  import minmax_scan_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int PORT       = 4,
  parameter int MINMAX     = MODE_MIN,
  localparam int LW        = $clog2(PORT)
) (
  input  logic [DATA_WIDTH*PORT-1:0] dat,
  output logic [DATA_WIDTH-1:0]      local_val,
  output logic [LW-1:0]              local_idx
);

  logic [DATA_WIDTH-1:0] elem;

  always_comb begin
    local_val = dat[DATA_WIDTH-1:0];
    local_idx = '0;
    elem      = '0;
    for (int j = 1; j < PORT; j++) begin
      elem = dat[DATA_WIDTH*j +: DATA_WIDTH];
      // strict compare keeps the earlier element on equality
      if ((MINMAX == MODE_MIN) ? (elem < local_val) : (elem > local_val)) begin
        local_val = elem;
        local_idx = LW'(j);
      end
    end
  end

endmodule

// File: rtl/minmax_scan_ctrl.sv
// Streams CFG_NUM beats through the MINMAX unit and holds the global min/max and index until consumed.
module minmax_scan_ctrl
  import minmax_scan_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int PORT       = 4,
  parameter int MINMAX     = MODE_MIN,
  parameter int CNT_WIDTH  = 12,
  parameter int IDX_WIDTH  = CNT_WIDTH + $clog2(PORT)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       CFG_START,
  input  logic [CNT_WIDTH-1:0]       CFG_NUM,
  output logic                       CFG_RDY,
  input  logic                       IN_VLD,
  output logic                       IN_RDY,
  input  logic [DATA_WIDTH*PORT-1:0] IN_DAT,
  output logic                       OUT_VLD,
  input  logic                       OUT_RDY,
  output logic [DATA_WIDTH-1:0]      OUT_VALUE,
  output logic [IDX_WIDTH-1:0]       OUT_IDX,
  output logic                       BUSY
);

  localparam int LW = $clog2(PORT);

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  num_q, cnt_q;
  logic [DATA_WIDTH-1:0] best_val;
  logic [IDX_WIDTH-1:0]  best_idx;
  logic [DATA_WIDTH-1:0] local_val;
  logic [LW-1:0]         local_idx;
  logic                  start_ok, accept, last_beat, better;

  minmax_scan_ctrl_minmax #(
    .DATA_WIDTH(DATA_WIDTH),
    .PORT      (PORT),
    .MINMAX    (MINMAX)
  ) u_minmax (
    .dat      (IN_DAT),
    .local_val(local_val),
    .local_idx(local_idx)
  );

  assign start_ok  = (state_q == IDLE) && CFG_START && (CFG_NUM != '0);
  assign accept    = IN_VLD && IN_RDY;
  assign last_beat = (cnt_q == num_q - CNT_WIDTH'(1));
  assign better    = (MINMAX == MODE_MIN) ? (local_val < best_val) : (local_val > best_val);

  always_comb begin
    state_d = state_q;
    CFG_RDY = 1'b0;
    IN_RDY  = 1'b0;
    OUT_VLD = 1'b0;
    BUSY    = 1'b0;
    case (state_q)
      IDLE: begin
        CFG_RDY = 1'b1;
        if (start_ok) state_d = SCAN;
      end
      SCAN: begin
        IN_RDY = 1'b1;
        BUSY   = 1'b1;
        if (accept && last_beat) state_d = DONE;
      end
      DONE: begin
        OUT_VLD = 1'b1;
        BUSY    = 1'b1;
        if (OUT_RDY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      num_q    <= '0;
      cnt_q    <= '0;
      best_val <= '0;
      best_idx <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        num_q <= CFG_NUM;
        cnt_q <= '0;
      end
      if (accept) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
        // first beat seeds the running best; later beats need a strict win
        if ((cnt_q == '0) || better) begin
          best_val <= local_val;
          best_idx <= IDX_WIDTH'({cnt_q, local_idx});
        end
      end
    end
  end

  assign OUT_VALUE = best_val;
  assign OUT_IDX   = best_idx;

endmodule
